// File: rtl/tdc_queue_pkg.sv
// Shared types and constants for the multi-channel TDC measurement queue.
// Holds the output FSM state type, busy-wait timeout and sequence tag width.
package tdc_queue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  localparam int TIMEOUT_CYC = 4;
  localparam int SEQ_W       = 8;

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO with fall-through head, occupancy level and full/empty.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module tdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // storage needs no reset; level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tdc_meas_queue.sv
// Per-channel capture, round-robin arbitration into a shared FIFO, UART drain.
// Define TDC_MEAS_SEQ_EN to append an 8-bit write sequence tag to each word.
module tdc_meas_queue
  import tdc_queue_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MEAS_W = 40,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8,
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef TDC_MEAS_SEQ_EN
  localparam int OUT_W = CH_BITS + MEAS_W + SEQ_W
`else
  localparam int OUT_W = CH_BITS + MEAS_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        meas_valid,
  input  logic [NUM_CH*MEAS_W-1:0] measurement,
  output logic [OUT_W-1:0]         tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic [NUM_CH*DROP_W-1:0] drop_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [MEAS_W-1:0]  word_q [NUM_CH];
  logic [MEAS_W-1:0]  word_d [NUM_CH];
  logic [DROP_W-1:0]  drop_q [NUM_CH];
  logic [DROP_W-1:0]  drop_d [NUM_CH];
  logic [CH_BITS-1:0] ptr_q, ptr_d;

  logic               gnt_vld;
  logic [CH_BITS-1:0] gnt_idx;
  logic [NUM_CH-1:0]  gnt_oh;

  logic [OUT_W-1:0]   push_data, head;
  logic               fifo_pop, fifo_empty;

  tx_state_e          state_q, state_d;
  logic [TO_W-1:0]    wcnt_q, wcnt_d;
  logic [OUT_W-1:0]   tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;

  // first pending channel at or after ptr_q, wrapping
  always_comb begin
    int c;
    logic [CH_BITS-1:0] cidx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      cidx = CH_BITS'(c);
      if (!gnt_vld && pend_q[cidx] && !fifo_full) begin
        gnt_vld      = 1'b1;
        gnt_idx      = cidx;
        gnt_oh[cidx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      if (gnt_idx == CH_BITS'(NUM_CH-1)) ptr_d = '0;
      else                               ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i] = pend_q[i];
      word_d[i] = word_q[i];
      drop_d[i] = drop_q[i];
      if (gnt_oh[i]) pend_d[i] = 1'b0;
      if (meas_valid[i]) begin
        if (!pend_q[i] || gnt_oh[i]) begin
          word_d[i] = measurement[i*MEAS_W +: MEAS_W];
          pend_d[i] = 1'b1;
        end else if (drop_q[i] != '1) begin
          drop_d[i] = drop_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef TDC_MEAS_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (gnt_vld) seq_d = seq_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end

  assign push_data = {gnt_idx, word_q[gnt_idx], seq_q};
`else
  assign push_data = {gnt_idx, word_q[gnt_idx]};
`endif

  tdc_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_vld),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_pop   = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          wcnt_d     = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // a UART that never raises busy still releases the word
        if (tx_busy)                             state_d = WAIT_DONE;
        else if (wcnt_q == TO_W'(TIMEOUT_CYC-1)) state_d = IDLE;
        else                                     wcnt_d  = wcnt_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      ptr_q      <= '0;
      state_q    <= IDLE;
      wcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        word_q[i] <= '0;
        drop_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      word_q     <= word_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drop
    assign drop_cnt[g*DROP_W +: DROP_W] = drop_q[g];
  end

endmodule

// File: tb/tb_tdc_meas_queue.sv
// Directed bench for tdc_meas_queue with a small UART busy model.
// Covers latency, ordering, round-robin, overflow, saturation and reset.
module tb_tdc_meas_queue;

  localparam int NUM_CH  = 4;
  localparam int MEAS_W  = 40;
  localparam int DEPTH   = 16;
  localparam int DROP_W  = 8;
  localparam int CH_BITS = 2;
  localparam int HI_W    = CH_BITS + MEAS_W;
`ifdef TDC_MEAS_SEQ_EN
  localparam int OUT_W = HI_W + 8;
`else
  localparam int OUT_W = HI_W;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        meas_valid;
  logic [NUM_CH*MEAS_W-1:0] measurement;
  logic [OUT_W-1:0]         tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     fifo_full;
  logic [NUM_CH*DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic stuck    = 1'b0;
  int   busy_len = 0;
  int   bcnt     = 0;

  logic [OUT_W-1:0] got [$];
  logic [HI_W-1:0]  sb  [$];

  tdc_meas_queue #(
    .NUM_CH (NUM_CH),
    .MEAS_W (MEAS_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .meas_valid  (meas_valid),
    .measurement (measurement),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .fifo_full   (fifo_full),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start && busy_len != 0) bcnt <= busy_len;
    else if (bcnt != 0)            bcnt <= bcnt - 1;
  end

  assign tx_busy = stuck | (bcnt != 0);

  always @(posedge clk) begin
    #1;
    if (tx_start) got.push_back(tx_data);
  end

  function automatic logic [HI_W-1:0] hi(input logic [OUT_W-1:0] w);
    return w[OUT_W-1 -: HI_W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    meas_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input int lim);
    int t;
    t = 0;
    while (got.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("wait_words", 64'(got.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [MEAS_W-1:0] val;
    int g;
    int n;
    int guard;

    rst = 1'b1;
    meas_valid = '0;
    measurement = '0;
    repeat (2) @(negedge clk);
    chk("rst_start", 64'(tx_start), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // single word latency
    @(negedge clk);
    got.delete();
    meas_valid = 4'b0100;
    measurement[2*MEAS_W +: MEAS_W] = 40'h00_0000_1234;
    @(negedge clk);
    meas_valid = '0;
    chk("t1_cyc1", 64'(tx_start), 64'd0);
    @(negedge clk);
    chk("t1_cyc2", 64'(tx_start), 64'd0);
    chk("t1_lvl1", 64'(fifo_level), 64'd1);
    @(negedge clk);
    chk("t1_start", 64'(tx_start), 64'd1);
    chk("t1_data", 64'(hi(tx_data)), {22'd0, 2'd2, 40'h1234});
    chk("t1_lvl0", 64'(fifo_level), 64'd0);
    @(negedge clk);
    chk("t1_pulse", 64'(tx_start), 64'd0);
    repeat (6) @(negedge clk);

    // all channels at once
    do_rst();
    got.delete();
    busy_len = 10;
    for (int i = 0; i < NUM_CH; i++)
      measurement[i*MEAS_W +: MEAS_W] = MEAS_W'(i+1);
    meas_valid = 4'hf;
    @(negedge clk);
    meas_valid = '0;
    wait_got(4, 200);
    for (int k = 0; k < 4; k++)
      chk("t2_word", 64'(hi(got[k])), (64'(k) << MEAS_W) | 64'(k+1));
    chk("t2_drop", 64'(drop_cnt), 64'd0);
    repeat (15) @(negedge clk);

    // round-robin between channels 0 and 3
    do_rst();
    got.delete();
    sb.delete();
    busy_len = 0;
    val = 40'h100;
    meas_valid = 4'b1001;
    measurement[0 +: MEAS_W] = val;
    sb.push_back({2'd0, val});
    val = val + 1;
    measurement[3*MEAS_W +: MEAS_W] = val;
    sb.push_back({2'd3, val});
    val = val + 1;
    @(negedge clk);
    g = 0;
    repeat (20) begin
      meas_valid = '0;
      if (!fifo_full) begin
        meas_valid[g] = 1'b1;
        measurement[g*MEAS_W +: MEAS_W] = val;
        sb.push_back({2'(g), val});
        val = val + 1;
        g = (g == 0) ? 3 : 0;
      end
      @(negedge clk);
    end
    meas_valid = '0;
    wait_got(sb.size(), 800);
    for (int k = 0; k < sb.size(); k++)
      chk("t3_word", 64'(hi(got[k])), 64'(sb[k]));
    chk("t3_drop", 64'(drop_cnt), 64'd0);

    // overflow with UART stuck busy
    do_rst();
    got.delete();
    stuck = 1'b1;
    for (int p = 1; p <= 20; p++) begin
      meas_valid = 4'b0010;
      measurement[MEAS_W +: MEAS_W] = 40'h2000 + MEAS_W'(p);
      @(negedge clk);
      meas_valid = '0;
      @(negedge clk);
    end
    chk("t4_level", 64'(fifo_level), 64'd16);
    chk("t4_full", 64'(fifo_full), 64'd1);
    chk("t4_drop", 64'(drop_cnt), 64'h300);
    stuck = 1'b0;
    wait_got(17, 600);
    chk("t4_first", 64'(hi(got[0])), {22'd0, 2'd1, 40'h2001});
    chk("t4_held", 64'(hi(got[16])), {22'd0, 2'd1, 40'h2011});
    chk("t4_empty", 64'(fifo_level), 64'd0);

    // drop saturation then reset during WAIT_DONE
    do_rst();
    got.delete();
    stuck = 1'b1;
    for (int p = 0; p < 330; p++) begin
      meas_valid = 4'b0001;
      measurement[0 +: MEAS_W] = 40'h3000 + MEAS_W'(p);
      @(negedge clk);
    end
    meas_valid = '0;
    chk("t5_sat", 64'(drop_cnt), 64'h0000_00ff);
    chk("t5_full", 64'(fifo_full), 64'd1);
    busy_len = 10;
    stuck = 1'b0;
    wait_got(1, 50);
    repeat (3) @(negedge clk);
    chk("t5_lvl_pre", 64'(fifo_level), 64'd16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_r_start", 64'(tx_start), 64'd0);
    chk("t5_r_data", 64'(tx_data), 64'd0);
    chk("t5_r_level", 64'(fifo_level), 64'd0);
    chk("t5_r_full", 64'(fifo_full), 64'd0);
    chk("t5_r_drop", 64'(drop_cnt), 64'd0);
    repeat (20) @(negedge clk);
    chk("t5_no_more", 64'(got.size()), 64'd1);

`ifdef TDC_MEAS_SEQ_EN
    // sequence tag wraps after 256 writes
    do_rst();
    got.delete();
    busy_len = 0;
    n = 0;
    guard = 0;
    while (n < 300 && guard < 5000) begin
      meas_valid = '0;
      if (!fifo_full) begin
        meas_valid[0] = 1'b1;
        measurement[0 +: MEAS_W] = MEAS_W'(n);
        n++;
      end
      @(negedge clk);
      guard++;
    end
    meas_valid = '0;
    wait_got(300, 4000);
    for (int k = 0; k < 300; k++)
      chk("seq_tag", 64'(got[k][7:0]), 64'(k % 256));
`else
    n = 0;
    guard = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_queue.md
Name: tdc_meas_queue

Overview:
- Multi-channel successor to the single-entry measurement buffer between TDC cores and the UART transmitter.
- Captures measurement words from NUM_CH TDC cores into per-channel pending registers.
- Arbitrates the pending words round-robin into one shared FIFO of DEPTH entries.
- Drains the FIFO to the UART as channel-tagged words using a start/busy handshake. Words dropped on overflow are counted per channel.

Parameters:
- NUM_CH, 4, number of TDC channels (1..16)
- MEAS_W, 40, measurement width per channel
- DEPTH, 16, FIFO depth in words; power of two, 2..256
- DROP_W, 8, width of each per-channel saturating drop counter

Ports:
- clk  in  1  single system clock (200 MHz domain)
- rst  in  1  synchronous, active-high reset
- meas_valid  in  NUM_CH  one-cycle valid pulse per channel
- measurement  in  NUM_CH*MEAS_W  flat bus; channel i occupies bits [i*MEAS_W +: MEAS_W]
- tx_data  out  OUT_W  word to UART: {ch_id[CH_BITS-1:0], meas[MEAS_W-1:0]}. CH_BITS = max(1, clog2(NUM_CH)); OUT_W = CH_BITS+MEAS_W (+8 with macro).
- tx_start  out  1  one-cycle start pulse to UART
- tx_busy  in  1  UART busy flag
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
- fifo_full  out  1  occupancy == DEPTH
- drop_cnt  out  NUM_CH*DROP_W  flat per-channel drop counters

Behaviour:
- Reset: all pending flags 0, FIFO empty, fifo_level 0, fifo_full 0, tx_start 0, tx_data 0, drop_cnt all 0, RR pointer at channel 0, FSM in IDLE.
- Capture, per channel, per cycle:
  - meas_valid with pending=0: word is registered and pending set.
  - meas_valid with pending=1 and the channel granted this cycle: new word replaces the pending word; pending stays 1.
  - meas_valid with pending=1 and not granted: new word is discarded and drop_cnt[i] increments, saturating at all-ones.
- Arbitration:
  - When the FIFO is not full, grant one pending channel per cycle.
  - Search starts at the channel after the last grant and wraps NUM_CH-1 to 0.
  - A grant writes {i, pending word} into the FIFO and clears pending, unless a replacement arrives as described under Capture.
  - No grants while the FIFO is full; pending words are held, not dropped.
- FIFO:
  - Synchronous, one write and one read per cycle.
  - A simultaneous push and pop while full is not possible, because no grant is issued when full.
  - Simultaneous push and pop at any other level leaves fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- Output FSM:
  - IDLE: if the FIFO is non-empty and tx_busy=0, pop the head, register it into tx_data, drive tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy=1, go to WAIT_DONE. If tx_busy is not seen within 4 cycles, return to IDLE; the word counts as sent.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- tx_data holds its value until the next pop.
- Latency: an isolated meas_valid sampled in cycle t, with an empty FIFO, an idle UART and no contention, gives tx_start high in cycle t+3.
- Ordering: each channel's words leave in capture order. Words from different channels interleave in grant order.
- Reset asserted mid-transfer: all state clears on the next edge and the FIFO contents are lost. The UART word already started is not affected.

Optional Feature:
- Macro: TDC_MEAS_SEQ_EN
- With the macro: an 8-bit sequence counter, reset to 0, increments on every FIFO write and wraps 255 to 0. Its value is stored with each word and appended as tx_data LSBs. OUT_W grows by 8. A gap in the sequence never appears, because drops happen before the FIFO write.
- Without the macro: no counter, and OUT_W = CH_BITS+MEAS_W.

Decomposition:
- Package tdc_queue_pkg holds:
  - the output FSM state enum (IDLE, WAIT_BUSY, WAIT_DONE);
  - the busy-wait timeout constant (4);
  - the sequence width constant (8).
- Sub-module tdc_sync_fifo (WIDTH, DEPTH): single-clock FIFO with level and full/empty flags. It is instantiated once. Arbitration, capture and the FSM stay in the top module.

Test Plan:
- Single word: channel 2 meas_valid with 40'h00_0000_1234, tx_busy held 0 -> tx_start in cycle t+3 with tx_data={2'd2,40'h1234}; fifo_level returns to 0.
- Simultaneous events: all 4 channels valid in the same cycle with values 1..4, then UART modelled with 10-cycle busy -> 4 words out, channel order 0,1,2,3; no drops.
- Round-robin fairness: channels 0 and 3 re-pulse every cycle they are granted, for 20 cycles -> grants alternate 0,3,0,3; drop_cnt stays 0.
- Overflow: DEPTH=16 with tx_busy stuck 1, channel 1 pulsed 20 times, one every 2 cycles:
  - FIFO reaches level 16 and fifo_full=1;
  - 1 word is held pending;
  - drop_cnt[1]=3.
- Saturation and reset: force 300 drops on channel 0 -> drop_cnt[0]=255. Assert rst for one cycle mid-WAIT_DONE -> all outputs return to their reset values on the next edge.
- TDC_MEAS_SEQ_EN: 300 words sent -> tx_data LSBs run 0..255 then 0..43.
